// File: rtl/pwm_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_cfg_sequencer
//  Purpose  : Wishbone master that buffers whole-channel PWM configuration
//             commands, validates them and writes stop/div/period/duty/ctrl
//             to a pwm_timer register file as ordered single writes.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_cfg_sequencer #(
  parameter int NUM_CHANNELS = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [2:0]  i_cmd_ch,
  input  logic [7:0]  i_cmd_ctrl,
  input  logic [15:0] i_cmd_div,
  input  logic [15:0] i_cmd_period,
  input  logic [15:0] i_cmd_dc,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [15:0] o_wb_adr,
  output logic [15:0] o_wb_data,
  input  logic        i_wb_ack,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [1:0]  o_err_code
);

  localparam int          c_aw      = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          c_cmd_w   = 3 + 8 + 16 + 16 + 16;
  localparam logic [3:0]  c_num_ch  = 4'(NUM_CHANNELS);
  localparam logic [15:0] c_to_last = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_WR    = 3'd2,
    S_GAP   = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_err_code;
  logic [1:0]          w_err_code_nxt;
  logic [2:0]          r_step;
  logic [15:0]         r_wait;

  logic [c_cmd_w-1:0]  r_fifo_mem [FIFO_DEPTH];
  logic [c_aw:0]       r_wr_ptr;
  logic [c_aw:0]       r_rd_ptr;
  logic                w_empty;
  logic                w_full;
  logic                w_push;
  logic                w_pop;

  logic [2:0]          r_cmd_ch;
  logic [7:0]          r_cmd_ctrl;
  logic [15:0]         r_cmd_div;
  logic [15:0]         r_cmd_period;
  logic [15:0]         r_cmd_dc;

  logic                w_wr;
  logic [2:0]          w_reg_sel;
  logic [15:0]         w_wr_data;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
                   (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
  assign w_push  = i_cmd_valid && !w_full;
  assign w_pop   = (r_state == S_IDLE) && !w_empty;

  // FIFO pointer update; reset empties the queue.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // FIFO storage; contents are meaningless until the write pointer covers them.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr[c_aw-1:0]] <= {i_cmd_ch, i_cmd_ctrl, i_cmd_div, i_cmd_period, i_cmd_dc};
    end
  end

  // Head of the FIFO is latched into the working command register on pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmd_ch     <= '0;
      r_cmd_ctrl   <= '0;
      r_cmd_div    <= '0;
      r_cmd_period <= '0;
      r_cmd_dc     <= '0;
    end else if (w_pop) begin
      {r_cmd_ch, r_cmd_ctrl, r_cmd_div, r_cmd_period, r_cmd_dc} <= r_fifo_mem[r_rd_ptr[c_aw-1:0]];
    end
  end

  // State register and held error code.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_err_code <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_err_code <= w_err_code_nxt;
    end
  end

  // Next-state logic; the error code changes only on the way into ERR so it
  // becomes visible in the same cycle as the o_err pulse.
  always_comb begin
    w_state_nxt    = r_state;
    w_err_code_nxt = r_err_code;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if ({1'b0, r_cmd_ch} >= c_num_ch) begin
          w_state_nxt    = S_ERR;
          w_err_code_nxt = 2'd1;
        end else if (r_cmd_div == 16'd0) begin
          w_state_nxt    = S_ERR;
          w_err_code_nxt = 2'd2;
        end else begin
          w_state_nxt = S_WR;
        end
      end
      S_WR: begin
        if (i_wb_ack) begin
          w_state_nxt = S_GAP;
        end else if (r_wait == c_to_last) begin
          w_state_nxt    = S_ERR;
          w_err_code_nxt = 2'd3;
        end
      end
      S_GAP:   w_state_nxt = (r_step == 3'd4) ? S_DONE : S_WR;
      S_DONE:  w_state_nxt = S_IDLE;
      S_ERR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Write step index: restarts at validation, advances once per gap cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_step <= 3'd0;
    end else if (r_state == S_CHECK) begin
      r_step <= 3'd0;
    end else if ((r_state == S_GAP) && (r_step != 3'd4)) begin
      r_step <= r_step + 3'd1;
    end
  end

  // Ack wait counter: held at zero outside WR so every write starts fresh.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait <= 16'd0;
    end else if (r_state != S_WR) begin
      r_wait <= 16'd0;
    end else if (!i_wb_ack) begin
      r_wait <= r_wait + 16'd1;
    end
  end

  // Register select and data for the current step; the final step re-targets
  // the ctrl register (reg 0) with the requested value.
  always_comb begin
    w_reg_sel = 3'd0;
    w_wr_data = 16'h0000;
    case (r_step)
      3'd1: begin w_reg_sel = 3'd1; w_wr_data = r_cmd_div;            end
      3'd2: begin w_reg_sel = 3'd2; w_wr_data = r_cmd_period;         end
      3'd3: begin w_reg_sel = 3'd3; w_wr_data = r_cmd_dc;             end
      3'd4: begin w_reg_sel = 3'd0; w_wr_data = {8'h00, r_cmd_ctrl};  end
      default: begin w_reg_sel = 3'd0; w_wr_data = 16'h0000;          end
    endcase
  end

  // Bus and status outputs decode straight from flops so they are glitch-free
  // and drop immediately when reset is asserted.
  assign w_wr        = (r_state == S_WR);
  assign o_wb_cyc    = w_wr;
  assign o_wb_stb    = w_wr;
  assign o_wb_we     = w_wr;
  assign o_wb_adr    = w_wr ? {10'b0, r_cmd_ch, w_reg_sel} : 16'h0000;
  assign o_wb_data   = w_wr ? w_wr_data : 16'h0000;
  assign o_cmd_ready = !w_full;
  assign o_busy      = (r_state != S_IDLE) || !w_empty;
  assign o_done      = (r_state == S_DONE);
  assign o_err       = (r_state == S_ERR);
  assign o_err_code  = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_pwm_cfg_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pwm_cfg_sequencer
//  Purpose  : Directed self-checking bench for pwm_cfg_sequencer with a
//             behavioural Wishbone slave holding a pwm_timer register image.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_cfg_sequencer;

  localparam int c_to = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_ch = '0;
  logic [7:0]  cmd_ctrl = '0;
  logic [15:0] cmd_div = '0;
  logic [15:0] cmd_period = '0;
  logic [15:0] cmd_dc = '0;
  logic        wb_cyc, wb_stb, wb_we;
  logic [15:0] wb_adr, wb_data;
  logic        wb_ack = 1'b0;
  logic        busy, done, err;
  logic [1:0]  err_code;

  pwm_cfg_sequencer #(.NUM_CHANNELS(4), .FIFO_DEPTH(4), .TIMEOUT(c_to)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_ch(cmd_ch), .i_cmd_ctrl(cmd_ctrl), .i_cmd_div(cmd_div),
    .i_cmd_period(cmd_period), .i_cmd_dc(cmd_dc),
    .o_wb_cyc(wb_cyc), .o_wb_stb(wb_stb), .o_wb_we(wb_we),
    .o_wb_adr(wb_adr), .o_wb_data(wb_data), .i_wb_ack(wb_ack),
    .o_busy(busy), .o_done(done), .o_err(err), .o_err_code(err_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slave model: 0 normal (ack on 2nd stb cycle), 1 stalled, 2 never acks
  // reg 2, 3 normal but holds ack for two cycles after each accepted write.
  int          mode = 0;
  int          s_cnt = 0;
  int          s_trail = 0;
  logic        prev_stb = 1'b0;
  int          stb_rises = 0;
  int          stb_cycles = 0;
  int          nack_cycles = 0;
  int          done_cnt = 0;
  int          err_cnt = 0;
  logic [1:0]  last_code = 2'd0;
  logic [15:0] log_adr[$];
  logic [15:0] log_dat[$];
  logic [15:0] regs[8][4];

  always @(negedge clk) begin
    if (!rst_n) begin
      wb_ack   = 1'b0;
      s_cnt    = 0;
      s_trail  = 0;
      prev_stb = 1'b0;
    end else begin
      if (wb_stb && !prev_stb) stb_rises++;
      prev_stb = wb_stb;
      if (done) done_cnt++;
      if (err) begin err_cnt++; last_code = err_code; end
      if (wb_stb) begin
        stb_cycles++;
        if (mode == 1) begin
          wb_ack = 1'b0;
        end else if (mode == 2 && wb_adr[2:0] == 3'd2) begin
          wb_ack = 1'b0;
          nack_cycles++;
        end else begin
          wb_ack = (s_cnt >= 1);
        end
        s_cnt++;
        if (wb_ack) begin
          log_adr.push_back(wb_adr);
          log_dat.push_back(wb_data);
          regs[wb_adr[5:3]][wb_adr[1:0]] = wb_data;
          s_trail = (mode == 3) ? 2 : 0;
        end
      end else begin
        s_cnt = 0;
        if (s_trail > 0) begin wb_ack = 1'b1; s_trail--; end
        else wb_ack = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; offers one command and returns at the negedge after acceptance.
  task automatic push(input logic [2:0] ch, input logic [7:0] ctrl,
                      input logic [15:0] dv, input logic [15:0] pr, input logic [15:0] dc);
    int n = 0;
    cmd_valid = 1'b1; cmd_ch = ch; cmd_ctrl = ctrl;
    cmd_div = dv; cmd_period = pr; cmd_dc = dc;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("push_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 600) begin @(negedge clk); n++; end
    chk("idle", 32'(busy), 32'd0);
  endtask

  function automatic logic [15:0] exp_adr(input logic [2:0] ch, input int k);
    logic [2:0] r;
    r = (k == 4) ? 3'd0 : 3'(k);
    return {10'b0, ch, r};
  endfunction

  function automatic logic [15:0] exp_dat(input logic [7:0] ctrl, input logic [15:0] dv,
                                          input logic [15:0] pr, input logic [15:0] dc, input int k);
    case (k)
      1: return dv;
      2: return pr;
      3: return dc;
      4: return {8'h00, ctrl};
      default: return 16'h0000;
    endcase
  endfunction

  task automatic check_cmd(input int start, input logic [2:0] ch, input logic [7:0] ctrl,
                           input logic [15:0] dv, input logic [15:0] pr, input logic [15:0] dc);
    if (log_adr.size() < start + 5) begin
      chk("log_len", 32'(log_adr.size()), 32'(start + 5));
    end else begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("adr[%0d]", start + k), 32'(log_adr[start+k]), 32'(exp_adr(ch, k)));
        chk($sformatf("dat[%0d]", start + k), 32'(log_dat[start+k]), 32'(exp_dat(ctrl, dv, pr, dc, k)));
      end
    end
  endtask

  logic [2:0]  t_ch  [5] = '{3'd0, 3'd3, 3'd2, 3'd1, 3'd0};
  logic [7:0]  t_ctl [5] = '{8'h16, 8'h06, 8'h12, 8'h96, 8'h40};
  logic [15:0] t_div [5] = '{16'd1, 16'd7, 16'd300, 16'hFFFF, 16'd5};
  logic [15:0] t_per [5] = '{16'd10, 16'd200, 16'h1234, 16'd9, 16'd0};
  logic [15:0] t_dc  [5] = '{16'd5, 16'd250, 16'h0001, 16'd4, 16'd77};

  int base, d0, e0, r0, s0, n;
  logic [15:0] exp1_adr [5] = '{16'h0008, 16'h0009, 16'h000A, 16'h000B, 16'h0008};
  logic [15:0] exp1_dat [5] = '{16'h0000, 16'h0002, 16'h0064, 16'h0019, 16'h0016};

  initial begin
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_cyc",   32'(wb_cyc), 32'd0);
    chk("rst_stb",   32'(wb_stb), 32'd0);
    chk("rst_we",    32'(wb_we), 32'd0);
    chk("rst_adr",   32'(wb_adr), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_code",  32'(err_code), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single command, 1-cycle-ack slave; push cycle + IDLE + CHECK precede stb
    base = log_adr.size(); d0 = done_cnt; s0 = stb_cycles;
    push(3'd1, 8'h16, 16'd2, 16'd100, 16'd25);
    n = 0;
    while (!wb_stb && n < 20) begin @(negedge clk); n++; end
    chk("first_stb_lat", 32'(n), 32'd2);
    wait_idle();
    chk("t1_len", 32'(log_adr.size() - base), 32'd5);
    if (log_adr.size() >= base + 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("t1_adr", 32'(log_adr[base+k]), 32'(exp1_adr[k]));
        chk("t1_dat", 32'(log_dat[base+k]), 32'(exp1_dat[k]));
      end
    end
    chk("t1_done", 32'(done_cnt - d0), 32'd1);
    chk("t1_stb_cycles", 32'(stb_cycles - s0), 32'd10);
    chk("t1_reg_ctrl", 32'(regs[1][0]), 32'h16);
    chk("t1_reg_div",  32'(regs[1][1]), 32'd2);
    chk("t1_reg_per",  32'(regs[1][2]), 32'd100);
    chk("t1_reg_dc",   32'(regs[1][3]), 32'd25);

    // Five back-to-back pushes against a stalled slave
    base = log_adr.size(); d0 = done_cnt;
    mode = 1;
    for (int i = 0; i < 5; i++) push(t_ch[i], t_ctl[i], t_div[i], t_per[i], t_dc[i]);
    chk("full_ready", 32'(cmd_ready), 32'd0);
    mode = 0;
    wait_idle();
    chk("t2_done", 32'(done_cnt - d0), 32'd5);
    for (int i = 0; i < 5; i++) check_cmd(base + 5 * i, t_ch[i], t_ctl[i], t_div[i], t_per[i], t_dc[i]);

    // Bad channel
    r0 = stb_rises; e0 = err_cnt;
    push(3'd4, 8'h16, 16'd2, 16'd100, 16'd25);
    wait_idle();
    chk("ch_err", 32'(err_cnt - e0), 32'd1);
    chk("ch_code", 32'(last_code), 32'd1);
    chk("ch_stb", 32'(stb_rises - r0), 32'd0);
    chk("ch_code_held", 32'(err_code), 32'd1);

    // Zero divisor
    push(3'd2, 8'h16, 16'd0, 16'd100, 16'd25);
    wait_idle();
    chk("div_err", 32'(err_cnt - e0), 32'd2);
    chk("div_code", 32'(last_code), 32'd2);
    chk("div_stb", 32'(stb_rises - r0), 32'd0);

    // Valid command after rejects (dc > period accepted)
    base = log_adr.size(); d0 = done_cnt;
    push(3'd3, 8'hD6, 16'd9, 16'd20, 16'd40);
    wait_idle();
    chk("after_err_done", 32'(done_cnt - d0), 32'd1);
    check_cmd(base, 3'd3, 8'hD6, 16'd9, 16'd20, 16'd40);

    // Slave never acks the period write
    base = log_adr.size(); d0 = done_cnt; e0 = err_cnt; r0 = stb_rises; nack_cycles = 0;
    mode = 2;
    push(3'd2, 8'h14, 16'd3, 16'd50, 16'd10);
    wait_idle();
    mode = 0;
    chk("to_err", 32'(err_cnt - e0), 32'd1);
    chk("to_code", 32'(last_code), 32'd3);
    chk("to_stb_cycles", 32'(nack_cycles), 32'(c_to));
    chk("to_writes", 32'(log_adr.size() - base), 32'd2);
    chk("to_rises", 32'(stb_rises - r0), 32'd3);
    chk("to_done", 32'(done_cnt - d0), 32'd0);
    base = log_adr.size();
    push(3'd2, 8'h14, 16'd3, 16'd50, 16'd10);
    wait_idle();
    chk("to_next_done", 32'(done_cnt - d0), 32'd1);
    check_cmd(base, 3'd2, 8'h14, 16'd3, 16'd50, 16'd10);

    // Trailing acks after each write
    base = log_adr.size(); d0 = done_cnt; r0 = stb_rises;
    mode = 3;
    push(3'd0, 8'h56, 16'd4, 16'd8, 16'd2);
    wait_idle();
    repeat (4) @(negedge clk);
    mode = 0;
    chk("trail_rises", 32'(stb_rises - r0), 32'd5);
    chk("trail_done", 32'(done_cnt - d0), 32'd1);
    check_cmd(base, 3'd0, 8'h56, 16'd4, 16'd8, 16'd2);

    // Reset during step 3 with a second command queued
    push(3'd3, 8'h16, 16'd2, 16'd100, 16'd25);
    push(3'd1, 8'h16, 16'd2, 16'd100, 16'd25);
    n = 0;
    while (!(wb_stb && wb_adr[2:0] == 3'd3) && n < 100) begin @(negedge clk); n++; end
    chk("rst_step3_seen", 32'(wb_adr[2:0]), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cyc", 32'(wb_cyc), 32'd0);
    chk("arst_stb", 32'(wb_stb), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    base = log_adr.size();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("arst_no_writes", 32'(log_adr.size()), 32'(base));
    chk("arst_idle", 32'(busy), 32'd0);
    chk("arst_ready", 32'(cmd_ready), 32'd1);
    chk("arst_code", 32'(err_code), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
